// File: rtl/dmem_resp.sv
// dmem_resp - data-memory responder for the memory stage.
//
// Accepts one load/store request at a time (valid/ready), waits WAIT_CYCLES
// extra cycles, performs the access and returns the result on a second
// valid/ready handshake. Handles RV32 byte/half/word sizing with sign/zero
// extension and reports illegal func3 (and optionally misalignment).
//
// Parameters:
//   XLEN        data/address width (the memory word is 32 bits; use 32)
//   DEPTH_LOG2  log2 of memory depth in 32-bit words
//   WAIT_CYCLES extra cycles between accept and access (0..15)
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   req_valid_i / req_ready_o       request handshake
//   req_we_i, req_addr_i,
//   req_wdata_i, req_func3_i        request payload (store data right-aligned)
//   rsp_valid_o / rsp_ready_i       response handshake
//   rsp_rdata_o, rsp_err_o          extended load data (0 for stores/errors), error
//
// Build option:
//   DMEM_MISALIGN_ERR_EN  defined: misaligned half/word accesses report an error.
//                         undefined: low address bits are forced to the access
//                         alignment and the access proceeds.
module dmem_resp #(
    parameter int XLEN        = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [2:0]      req_func3_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // WAIT is held for WAIT_CYCLES+1 cycles (counter runs WAIT_CYCLES..0, the
    // access happens on the zero cycle), giving a 1+WAIT_CYCLES latency.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      func3_q, func3_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    // Access operands: live request in IDLE (zero-wait path), latched otherwise.
    logic            acc_we;
    logic [XLEN-1:0] acc_addr;
    logic [XLEN-1:0] acc_wdata;
    logic [2:0]      acc_func3;
    logic            do_access;

    logic [DEPTH_LOG2-1:0] widx;
    logic [1:0]      size;
    logic [1:0]      lo;
    logic            illegal;
    logic            misalign;
    logic            acc_err;
    logic [3:0]      be;
    logic [31:0]     wr_data;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;
    logic [XLEN-1:0] acc_rdata;
    logic            unused_bits;

    assign acc_we    = (state_q == S_IDLE) ? req_we_i    : we_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
    assign acc_func3 = (state_q == S_IDLE) ? req_func3_i : func3_q;

    // Upper address bits alias; the memory wraps.
    assign widx = acc_addr[DEPTH_LOG2+1:2];

    // Byte-lane memory: one array per lane so partial stores need no read-modify-write.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        always_ff @(posedge clk_i) begin
            if (do_access && be[gi]) begin
                mem[widx] <= wr_data[8*gi +: 8];
            end
        end
        assign rd_word[8*gi +: 8] = mem[widx];
    end

    always_comb begin
        size = acc_func3[1:0];
        // Lane offset forced to the access alignment; with misalignment
        // checking enabled the unaligned cases are rejected before this matters.
        case (size)
            2'b00:   lo = acc_addr[1:0];
            2'b01:   lo = {acc_addr[1], 1'b0};
            default: lo = 2'b00;
        endcase
        if (acc_we) begin
            illegal = acc_func3[2] | (size == 2'b11);
        end else begin
            illegal = (size == 2'b11) | (acc_func3[2] & (size == 2'b10));
        end
`ifdef DMEM_MISALIGN_ERR_EN
        misalign = ((size == 2'b01) && acc_addr[0]) ||
                   ((size == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        acc_err = illegal | misalign;

        be      = 4'b0000;
        wr_data = acc_wdata[31:0];
        case (size)
            2'b00: begin
                be      = 4'b0001 << lo;
                wr_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be      = 4'b0011 << lo;
                wr_data = {2{acc_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!acc_we || acc_err || !do_access) begin
            be = 4'b0000;
        end

        rd_shift  = rd_word >> {lo, 3'b000};
        acc_rdata = '0;
        if (!acc_we && !acc_err) begin
            case (size)
                2'b00: acc_rdata = acc_func3[2] ? {{(XLEN-8){1'b0}}, rd_shift[7:0]}
                                                : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
                2'b01: acc_rdata = acc_func3[2] ? {{(XLEN-16){1'b0}}, rd_shift[15:0]}
                                                : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
                default: acc_rdata = rd_word;
            endcase
        end
    end

    assign unused_bits = ^{acc_addr[XLEN-1:DEPTH_LOG2+2], rd_shift[31:16]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        func3_d     = func3_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        do_access   = 1'b0;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    func3_d = req_func3_i;
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        rdata_d   = acc_rdata;
                        err_d     = acc_err;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    rdata_d   = acc_rdata;
                    err_d     = acc_err;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            func3_q <= 3'b000;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: vector table plus hand-written backpressure and
// reset-abort sequences; responses checked against a queue of expectations.
module tb_dmem_resp;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_func3 = 3'b000;
    logic        rsp_valid_o;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    dmem_resp #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_func3_i (req_func3),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input logic [31:0] er, input logic ee);
        mk.we = we; mk.addr = addr; mk.wdata = wdata; mk.f3 = f3; mk.er = er; mk.ee = ee;
    endfunction

    function automatic exp_t mke(input logic [31:0] rdata, input logic err, input int id);
        mke.rdata = rdata; mke.err = err; mke.id = id;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s id=%0d got=%h want=%h", nm, id, act, exp);
        end else begin
            $display("ok   %s id=%0d value=%h", nm, id, act);
        end
    endtask

    // Waits for the response following an accept edge, checks latency and payload, then hands it off.
    task automatic wait_rsp();
        int   lat;
        exp_t e;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rsp_valid_o && lat < 40);
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty got=0 want=1");
        end else begin
            e = sb.pop_front();
            chk("latency", e.id, 32'(lat), 32'(1 + W));
            chk("rsp_valid", e.id, {31'd0, rsp_valid_o}, 32'd1);
            chk("rdata", e.id, rsp_rdata_o, e.rdata);
            chk("err", e.id, {31'd0, rsp_err_o}, {31'd0, e.err});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("valid_drop", e.id, {31'd0, rsp_valid_o}, 32'd0);
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] er, input logic ee, input int id);
        int k;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_func3 = f3;
        k = 0;
        while (!req_ready_o && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("req_ready", id, {31'd0, req_ready_o}, 32'd1);
        sb.push_back(mke(er, ee, id));
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp();
    endtask

    initial begin
        vecs.push_back(mk(1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        0));
        vecs.push_back(mk(0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 32'h11,   32'h00000055, 3'b000, 32'h0,        0));
        vecs.push_back(mk(0, 32'h10,   32'h0,        3'b010, 32'hDEAD55EF, 0));
        vecs.push_back(mk(0, 32'h13,   32'h0,        3'b000, 32'hFFFFFFDE, 0));
        vecs.push_back(mk(0, 32'h13,   32'h0,        3'b100, 32'h000000DE, 0));
        vecs.push_back(mk(0, 32'h12,   32'h0,        3'b001, 32'hFFFFDEAD, 0));
        vecs.push_back(mk(0, 32'h12,   32'h0,        3'b101, 32'h0000DEAD, 0));
        vecs.push_back(mk(0, 32'h10,   32'h0,        3'b000, 32'hFFFFFFEF, 0));
        vecs.push_back(mk(1, 32'h16,   32'hABCD1234, 3'b001, 32'h0,        0));
        vecs.push_back(mk(0, 32'h16,   32'h0,        3'b101, 32'h00001234, 0));
        vecs.push_back(mk(0, 32'h10,   32'h0,        3'b011, 32'h0,        1));
        vecs.push_back(mk(0, 32'h10,   32'h0,        3'b110, 32'h0,        1));
        vecs.push_back(mk(1, 32'h10,   32'h0,        3'b100, 32'h0,        1));
        vecs.push_back(mk(0, 32'h10,   32'h0,        3'b010, 32'hDEAD55EF, 0));
        vecs.push_back(mk(0, 32'h1010, 32'h0,        3'b010, 32'hDEAD55EF, 0));
        vecs.push_back(mk(1, 32'h1020, 32'hCAFEF00D, 3'b010, 32'h0,        0));
        vecs.push_back(mk(0, 32'h20,   32'h0,        3'b010, 32'hCAFEF00D, 0));
`ifdef DMEM_MISALIGN_ERR_EN
        vecs.push_back(mk(1, 32'h22,   32'h8765ABCD, 3'b010, 32'h0,        1));
        vecs.push_back(mk(0, 32'h20,   32'h0,        3'b010, 32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 32'h21,   32'h0,        3'b001, 32'h0,        1));
        vecs.push_back(mk(0, 32'h13,   32'h0,        3'b010, 32'h0,        1));
`else
        vecs.push_back(mk(1, 32'h22,   32'h8765ABCD, 3'b010, 32'h0,        0));
        vecs.push_back(mk(0, 32'h20,   32'h0,        3'b010, 32'h8765ABCD, 0));
        vecs.push_back(mk(0, 32'h21,   32'h0,        3'b001, 32'hFFFFABCD, 0));
        vecs.push_back(mk(0, 32'h13,   32'h0,        3'b010, 32'hDEAD55EF, 0));
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 0, {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rdata", 0, rsp_rdata_o, 32'd0);
        chk("rst_err",   0, {31'd0, rsp_err_o}, 32'd0);
        chk("rst_ready", 0, {31'd0, req_ready_o}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, vecs[i].er, vecs[i].ee, i + 1);
        end

        // Backpressure: response held, a pending request must wait for IDLE.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = '0; req_func3 = 3'b010;
        chk("bp_ready", 100, {31'd0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0BADF00D;
        for (int k = 0; k < 40 && !rsp_valid_o; k++) begin
            @(posedge clk); #1;
        end
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 100 + c, {31'd0, rsp_valid_o}, 32'd1);
            chk("bp_rdata", 100 + c, rsp_rdata_o, 32'hDEAD55EF);
            chk("bp_req_ready", 100 + c, {31'd0, req_ready_o}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_valid_drop", 105, {31'd0, rsp_valid_o}, 32'd0);
        chk("bp_idle_ready", 105, {31'd0, req_ready_o}, 32'd1);
        sb.push_back(mke(32'h0, 1'b0, 106));
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp();
        send(0, 32'h40, 32'h0, 3'b010, 32'h0BADF00D, 0, 107);

        // Reset while a store waits: the store must never land.
        send(1, 32'h30, 32'hA5A5A5A5, 3'b010, 32'h0, 0, 200);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_func3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", 201, {31'd0, rsp_valid_o}, 32'd0);
        chk("abort_ready", 201, {31'd0, req_ready_o}, 32'd1);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_quiet", 202, {31'd0, rsp_valid_o}, 32'd0);
        send(0, 32'h30, 32'h0, 3'b010, 32'hA5A5A5A5, 0, 203);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
